// File: rtl/lvds_pll_lock_ctrl.sv
// PLL reset/lock sequencer for the LVDS SERDES, clocked only from refclk.
// Latency: lock seen 2 edges after pll_locked rises (sync), ready LOCK_STABLE_CYC edges later.
// Backpressure: none; relock_req is accepted every cycle and overrides all other events.
module lvds_pll_lock_ctrl #(
    parameter int RST_PULSE_CYC    = 16,
    parameter int LOCK_STABLE_CYC  = 1024,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int MAX_RETRY        = 3
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       lvds_rst_n,
    output logic       ready,
    output logic       fault,
    output logic       lock_lost,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam int CW = $clog2(LOCK_TIMEOUT_CYC);

    // PRST is entered with the counter at 1, except out of reset where it starts at 0,
    // so the first edge after rst_n release opens the pulse window.
    localparam logic [CW-1:0] PRST_LAST   = CW'(RST_PULSE_CYC);
    localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] STB_LAST    = CW'(LOCK_STABLE_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [3:0]    RETRY_LIMIT = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_PRST   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_STABLE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    logic          sync_q1;
    logic          locked_s;
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [3:0]    retry_nxt;
    logic [3:0]    retry_inc;
    logic [7:0]    loss_nxt;
    logic          lost_nxt;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1  <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_q1  <= pll_locked;
            locked_s <= sync_q1;
        end
    end

    assign retry_inc = retry_cnt + 4'd1;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry_cnt;
        loss_nxt  = loss_cnt;
        lost_nxt  = 1'b0;
        if (relock_req) begin
            state_nxt = ST_PRST;
            cnt_nxt   = CNT_ONE;
            retry_nxt = 4'd0;
        end else begin
            case (state)
                ST_PRST: begin
                    if (cnt == PRST_LAST) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    if (locked_s) begin
                        state_nxt = ST_STABLE;
                        cnt_nxt   = '0;
                    end else if (cnt == TMO_LAST) begin
                        retry_nxt = retry_inc;
                        if (retry_inc == RETRY_LIMIT) begin
                            state_nxt = ST_FAULT;
                            cnt_nxt   = '0;
                        end else begin
                            state_nxt = ST_PRST;
                            cnt_nxt   = CNT_ONE;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_nxt = ST_WAIT;
                        cnt_nxt   = '0;
                    end else if (cnt == STB_LAST) begin
                        state_nxt = ST_RUN;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state_nxt = ST_PRST;
                        cnt_nxt   = CNT_ONE;
                        retry_nxt = 4'd0;
                        lost_nxt  = 1'b1;
                        if (loss_cnt != 8'hFF) begin
                            loss_nxt = loss_cnt + 8'd1;
                        end
                    end
                end
                ST_FAULT: begin
                    cnt_nxt = '0;
                end
                default: begin
                    state_nxt = ST_PRST;
                    cnt_nxt   = CNT_ONE;
                end
            endcase
        end
    end

    // Outputs decode the next state so every output moves on its transition edge.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_PRST;
            cnt        <= '0;
            retry_cnt  <= 4'd0;
            loss_cnt   <= 8'd0;
            lock_lost  <= 1'b0;
            pll_rst    <= 1'b1;
            lvds_rst_n <= 1'b0;
            ready      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            retry_cnt  <= retry_nxt;
            loss_cnt   <= loss_nxt;
            lock_lost  <= lost_nxt;
            pll_rst    <= (state_nxt == ST_PRST) || (state_nxt == ST_FAULT);
            lvds_rst_n <= (state_nxt == ST_RUN);
            ready      <= (state_nxt == ST_RUN);
            fault      <= (state_nxt == ST_FAULT);
        end
    end

endmodule

// File: doc/lvds_pll_lock_ctrl.md
LVDS_PLL_LOCK_CTRL -- requirements
Module: lvds_pll_lock_ctrl

Interface
REQ-001 Parameter RST_PULSE_CYC, default 16: number of refclk cycles the PLL reset is held per attempt (min 2).
REQ-002 Parameter LOCK_STABLE_CYC, default 1024: number of consecutive synchronized-lock cycles required before the link is declared ready (min 1).
REQ-003 Parameter LOCK_TIMEOUT_CYC, default 65536: maximum number of cycles spent waiting for lock per attempt (min 4).
REQ-004 Parameter MAX_RETRY, default 3: number of failed lock attempts that causes the block to enter FAULT (1..15).
REQ-005 Port refclk, input, 1: free-running 50 MHz reference clock; the single clock of the block. The block shall never be clocked from any PLL output.
REQ-006 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-007 Port pll_locked, input, 1: PLL locked flag, asynchronous to refclk.
REQ-008 Port relock_req, input, 1: single-cycle software request to restart the lock sequence.
REQ-009 Port pll_rst, output, 1: active-high reset to the PLL.
REQ-010 Port lvds_rst_n, output, 1: active-low reset to the LVDS SERDES datapath.
REQ-011 Port ready, output, 1: PLL is locked and the datapath is released.
REQ-012 Port fault, output, 1: retry budget is exhausted.
REQ-013 Port lock_lost, output, 1: one-cycle pulse on loss of lock while in RUN.
REQ-014 Port retry_cnt, output, 4: number of failed attempts in the current sequence.
REQ-015 Port loss_cnt, output, 8: count of lock-loss events, saturating at 255.

Function
REQ-016 pll_locked shall be passed through a 2-flop synchronizer, producing locked_s; all decisions shall use locked_s only.
REQ-017 States: PRST, WAIT, STABLE, RUN, FAULT, held in one registered state register with a single shared cycle counter.
REQ-018 PRST: pll_rst=1. Stay exactly RST_PULSE_CYC cycles, then go to WAIT with the counter cleared.
REQ-019 WAIT, transition to STABLE: if locked_s=1, go to STABLE and clear the counter.
REQ-020 WAIT, timeout: if the counter reaches LOCK_TIMEOUT_CYC-1 with locked_s=0, increment retry_cnt. Go to FAULT if the new value equals MAX_RETRY, otherwise go to PRST.
REQ-021 STABLE, return to WAIT: if locked_s=0, go back to WAIT with the counter cleared; retry_cnt is unchanged.
REQ-022 STABLE, transition to RUN: after LOCK_STABLE_CYC consecutive cycles in STABLE with locked_s=1, go to RUN.
REQ-023 RUN: ready=1 and lvds_rst_n=1. On locked_s=0, pulse lock_lost for one cycle, increment loss_cnt (saturating), clear retry_cnt, and go to PRST.
REQ-024 FAULT: pll_rst=1, fault=1. Leave FAULT only on relock_req or reset.
REQ-025 relock_req in any state shall go to PRST on the next edge, clear retry_cnt and fault, and leave loss_cnt unchanged. It takes priority over timeout, lock loss and stability completion in the same cycle.
REQ-026 pll_rst shall be 1 in PRST and FAULT, and 0 otherwise.
REQ-027 lvds_rst_n and ready shall be 1 only in RUN. lvds_rst_n shall fall on the same edge that RUN is exited.
REQ-028 All outputs shall be registered, decoded from the next state, so each output changes on the edge of its state transition.
REQ-029 The counter width shall be clog2(LOCK_TIMEOUT_CYC). The counter shall not wrap within any state.
REQ-030 Latency: with pll_locked rising before edge k, STABLE is entered at edge k+2 and ready rises at edge k+2+LOCK_STABLE_CYC.

Reset
REQ-031 While rst_n=0, asynchronously: state=PRST, counter=0, pll_rst=1, lvds_rst_n=0, ready=0, fault=0, lock_lost=0, retry_cnt=0, loss_cnt=0, and both synchronizer flops=0.
REQ-032 Reset asserted mid-sequence, including in RUN, shall force the REQ-031 values immediately, with no glitch on pll_rst.
REQ-033 After rst_n deasserts, the block shall start in PRST, and pll_rst shall stay high for RST_PULSE_CYC cycles counted from the first refclk edge.

Verification (RST_PULSE_CYC=4, LOCK_STABLE_CYC=8, LOCK_TIMEOUT_CYC=32, MAX_RETRY=2)
REQ-034 Nominal lock: release rst_n, raise pll_locked 10 cycles later -> pll_rst high exactly 4 cycles; ready and lvds_rst_n rise 10 edges after pll_locked rises; fault=0; retry_cnt=0.
REQ-035 Timeout to fault: pll_locked held at 0 -> two PRST/WAIT attempts of 4+32 cycles each; retry_cnt steps 1 then 2; fault=1 and pll_rst=1 held indefinitely.
REQ-036 Glitchy lock: pll_locked high for 5 cycles, low for 2, then high -> STABLE falls back to WAIT; ready rises only after 8 uninterrupted cycles; retry_cnt=0.
REQ-037 Loss in RUN: drop pll_locked in RUN -> lock_lost pulses for exactly 1 cycle; loss_cnt increments by 1; ready and lvds_rst_n go to 0; pll_rst=1 for 4 cycles; relock succeeds with pll_locked=1.
REQ-038 Recovery and priority: relock_req in FAULT -> fault=0, retry_cnt=0, PRST entered. Separately, relock_req in the same cycle as a WAIT timeout -> retry_cnt=0, not incremented.
REQ-039 Reset in RUN: assert rst_n=0 asynchronously -> pll_rst=1, ready=0 and loss_cnt=0 before the next refclk edge.
